fetch_sequencer: RTL and testbench

Instruction fetch sequencer for the 8-bit CPU. Owns the program counter, drives the program ROM's `addr`/`read`/`ena` inputs, and assembles one- and two-byte instructions from the ROM data bus. It hands each decoded instruction to the execute unit over a valid/ready handshake. JMP, NOP and HLT are resolved locally and never issued.

---
 rtl/fetch_sequencer.sv | 101 ++++++++++
 tb/tb_fetch_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the 8-bit CPU. Walks the program ROM, resolves
// NOP/JMP/HLT locally and hands every other instruction to execute over valid/ready.
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rom_data,
    output logic [7:0] rom_addr,
    output logic       rom_read,
    output logic       rom_ena,
    output logic       ins_valid,
    input  logic       ins_ready,
    output logic [3:0] ins_op,
    output logic [3:0] ins_reg,
    output logic [7:0] ins_arg,
    output logic       ins_two,
    output logic       halted
);
    localparam logic [1:0] FETCH_OP  = 2'd0;
    localparam logic [1:0] FETCH_ARG = 2'd1;
    localparam logic [1:0] ISSUE     = 2'd2;
    localparam logic [1:0] HALT      = 2'd3;

    localparam logic [3:0] OP_JMP = 4'b1010;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [1:0] state;
    logic [7:0] pc;
    logic [3:0] fetched_op;
    logic       op_two;
    logic       op_local;
    logic       fetching;

    assign fetched_op = rom_data[7:4];

    always_comb begin
        op_two   = 1'b0;
        op_local = 1'b0;
        case (fetched_op)
            4'b0001, 4'b0010, 4'b0011, OP_JMP: op_two   = 1'b1;
            4'b0000, 4'b1101, 4'b1110:         op_local = 1'b1;
            default: ;
        endcase
    end

    // Reset parks the FSM in FETCH_OP, so the strobes are also masked by rst_n.
    assign fetching  = rst_n && ((state == FETCH_OP) || (state == FETCH_ARG));
    assign rom_read  = fetching;
    assign rom_ena   = fetching;
    assign rom_addr  = pc;
    assign ins_valid = (state == ISSUE);
    assign halted    = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH_OP;
            pc      <= RESET_PC;
            ins_op  <= '0;
            ins_reg <= '0;
            ins_arg <= '0;
            ins_two <= 1'b0;
        end else begin
            case (state)
                FETCH_OP: begin
                    ins_op  <= rom_data[7:4];
                    ins_reg <= rom_data[3:0];
                    pc      <= pc + 8'd1;
                    if (op_two) begin
                        state <= FETCH_ARG;
                    end else if (fetched_op == OP_HLT) begin
                        state <= HALT;
                    end else if (op_local) begin
                        state <= FETCH_OP;
                    end else begin
                        ins_arg <= '0;
                        ins_two <= 1'b0;
                        state   <= ISSUE;
                    end
                end
                FETCH_ARG: begin
                    if (ins_op == OP_JMP) begin
                        pc    <= rom_data;
                        state <= FETCH_OP;
                    end else begin
                        ins_arg <= rom_data;
                        ins_two <= 1'b1;
                        pc      <= pc + 8'd1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ins_ready) begin
                        state <= FETCH_OP;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: a program-walking reference model fills the
// expected queue, a negedge monitor pops on each new instruction and checks it.
module tb_fetch_sequencer;
    typedef struct {
        logic [3:0] op;
        logic [3:0] rg;
        logic [7:0] arg;
        logic       two;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ins_ready = 1'b1;
    logic [7:0] junk = 8'h00;

    logic [7:0] a_data, a_addr, a_arg;
    logic       a_read, a_ena, a_valid, a_two, a_halted;
    logic [3:0] a_op, a_reg;
    logic [7:0] b_data, b_addr, b_arg;
    logic       b_read, b_ena, b_valid, b_two, b_halted;
    logic [3:0] b_op, b_reg;

    logic [7:0] rom_a [256];
    logic [7:0] rom_b [256];

    exp_t exp_q [$];
    exp_t cur;
    int   tests = 0;
    int   fails = 0;
    bit   sb_on = 0;
    bit   in_issue = 0;
    bit   halt_seen = 0;
    bit   exp_halt = 0;
    int   exp_halt_gap = 0;
    int   idle = 0;
    bit   rand_ready = 0;
    bit   ready_val = 1;

    always #5 clk = ~clk;
    always @(posedge clk) junk <= 8'($urandom);

    assign a_data = (a_read && a_ena) ? rom_a[a_addr] : junk;
    assign b_data = (b_read && b_ena) ? rom_b[b_addr] : junk;

    fetch_sequencer #(.RESET_PC(8'd0)) dut (
        .clk(clk), .rst_n(rst_n), .rom_data(a_data), .rom_addr(a_addr),
        .rom_read(a_read), .rom_ena(a_ena), .ins_valid(a_valid), .ins_ready(ins_ready),
        .ins_op(a_op), .ins_reg(a_reg), .ins_arg(a_arg), .ins_two(a_two), .halted(a_halted)
    );

    fetch_sequencer #(.RESET_PC(8'hFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .rom_data(b_data), .rom_addr(b_addr),
        .rom_read(b_read), .rom_ena(b_ena), .ins_valid(b_valid), .ins_ready(1'b1),
        .ins_op(b_op), .ins_reg(b_reg), .ins_arg(b_arg), .ins_two(b_two), .halted(b_halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Walks the ROM image the way the CPU would and records every issued instruction
    // together with the number of fetch cycles that precede its first valid cycle.
    task automatic model_run(input int start, input int max_ins);
        int pc, gap, n, k;
        logic [7:0] b;
        exp_t e;
        pc = start; gap = 0; n = 0;
        exp_halt = 0; exp_halt_gap = 0;
        while (n < max_ins && gap < 64) begin
            b = rom_a[pc];
            pc = (pc + 1) % 256;
            k = int'(b[7:4]);
            if (k == 15) begin
                exp_halt = 1;
                exp_halt_gap = gap + 1;
                break;
            end else if (k == 0 || k == 13 || k == 14) begin
                gap += 1;
            end else if (k == 10) begin
                pc = int'(rom_a[pc]);
                gap += 2;
            end else begin
                e.op = b[7:4]; e.rg = b[3:0]; e.arg = 8'h00; e.two = 1'b0;
                if (k >= 1 && k <= 3) begin
                    e.arg = rom_a[pc];
                    e.two = 1'b1;
                    pc = (pc + 1) % 256;
                    gap += 2;
                end else begin
                    gap += 1;
                end
                e.gap = gap;
                exp_q.push_back(e);
                gap = 0;
                n++;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ins_ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_val;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            idle = 0; in_issue = 0; halt_seen = 0;
        end else if (sb_on) begin
            if (a_valid) begin
                if (!in_issue) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_issue", {a_op, a_reg, a_arg}, 0);
                        cur.op = a_op; cur.rg = a_reg; cur.arg = a_arg; cur.two = a_two; cur.gap = 0;
                    end else begin
                        cur = exp_q.pop_front();
                        check("issue_gap", idle, cur.gap);
                        check("ins_op", a_op, cur.op);
                        check("ins_reg", a_reg, cur.rg);
                        check("ins_arg", a_arg, cur.arg);
                        check("ins_two", a_two, cur.two);
                    end
                    in_issue = 1;
                end else begin
                    check("held_stable", {a_op, a_reg, a_arg, a_two}, {cur.op, cur.rg, cur.arg, cur.two});
                end
                if (ins_ready) begin
                    in_issue = 0;
                    idle = 0;
                end
            end else begin
                if (in_issue) begin
                    check("valid_dropped", a_valid, 1);
                    in_issue = 0;
                end
                if (a_halted && !halt_seen) begin
                    halt_seen = 1;
                    check("halt_expected", a_halted, exp_halt);
                    check("halt_gap", idle, exp_halt_gap);
                    check("halt_q_empty", exp_q.size(), 0);
                end
                idle++;
            end
        end
    end

    task automatic do_reset();
        sb_on = 0;
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("reset_state", {a_valid, a_read, a_ena, a_op, a_reg, a_arg, a_two, a_halted}, 0);
        check("reset_strobes_wrap", {b_read, b_ena, b_valid, b_halted}, 0);
        exp_q.delete();
        model_run(0, 25);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        sb_on = 1;
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!(exp_q.size() == 0 && !in_issue && (!exp_halt || halt_seen)) && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        check("drain_timeout", cyc >= 3000, 0);
        sb_on = 0;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) rom_a[i] = v;
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 256; i++) rom_b[i] = 8'hF0;

        // Reset release: NOP@0, INC r1@1.
        fill(8'hF0); rom_a[0] = 8'h00; rom_a[1] = 8'h81;
        ready_val = 1;
        do_reset();
        @(negedge clk); check("t1_c0_addr", {a_addr, a_read, a_ena}, {8'd0, 2'b11});
        @(negedge clk); check("t1_c1_addr", a_addr, 8'd1);
        @(negedge clk); check("t1_c2_ins", {a_valid, a_op, a_reg, a_arg, a_two}, {1'b1, 4'h8, 4'h1, 8'h00, 1'b0});
        wait_done();

        // JMP 0x0F from address 7.
        fill(8'hF0);
        for (int i = 0; i < 7; i++) rom_a[i] = 8'h00;
        rom_a[7] = 8'hA3; rom_a[8] = 8'h0F;
        for (int i = 9; i < 16; i++) rom_a[i] = 8'h81;
        do_reset();
        repeat (8) @(negedge clk);
        check("t2_jmp_fetch", a_addr, 8'd7);
        @(negedge clk); check("t2_arg_fetch", {a_valid, a_addr}, {1'b0, 8'd8});
        @(negedge clk); check("t2_target", {a_valid, a_addr}, {1'b0, 8'd15});
        @(negedge clk); check("t2_inc_valid", {a_valid, a_op}, {1'b1, 4'h8});
        wait_done();

        // LDO r1,0x41 at 18 with ready held low for three cycles.
        fill(8'hF0); rom_a[0] = 8'hA0; rom_a[1] = 8'd18;
        rom_a[18] = 8'h11; rom_a[19] = 8'h41; rom_a[20] = 8'h81;
        ready_val = 0;
        do_reset();
        repeat (3) @(negedge clk);
        check("t3_op_fetch", a_addr, 8'd18);
        @(negedge clk); check("t3_arg_fetch", a_addr, 8'd19);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_hold", {a_valid, a_op, a_reg, a_arg, a_two}, {1'b1, 4'h1, 4'h1, 8'h41, 1'b1});
        end
        ready_val = 1;
        @(negedge clk); check("t3_accept_cycle", {a_valid, ins_ready}, 2'b11);
        @(negedge clk); check("t3_next_fetch", {a_valid, a_addr, a_read}, {1'b0, 8'd20, 1'b1});
        wait_done();

        // HLT at 39 persists until reset.
        fill(8'h81); rom_a[0] = 8'hA0; rom_a[1] = 8'd39; rom_a[39] = 8'hF0;
        do_reset();
        repeat (3) @(negedge clk); check("t4_hlt_fetch", a_addr, 8'd39);
        @(negedge clk); check("t4_halted", {a_halted, a_ena, a_read, a_valid}, 4'b1000);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if ({a_halted, a_ena, a_read, a_valid} !== 4'b1000) bad++;
        end
        check("t4_halt_persist", bad, 0);
        wait_done();
        #2 rst_n = 0;
        #1 check("t4_reset_unhalts", a_halted, 0);

        // Asynchronous reset in the middle of ISSUE.
        fill(8'hF0); rom_a[0] = 8'h81;
        ready_val = 0;
        do_reset();
        @(negedge clk);
        @(negedge clk); check("t5_issue", a_valid, 1);
        #2 rst_n = 0;
        #1 check("t5_async_drop", {a_valid, a_read, a_ena}, 0);
        ready_val = 1;
        do_reset();
        @(negedge clk); check("t5_restart", {a_addr, a_read, a_ena}, {8'd0, 2'b11});
        wait_done();

        // RESET_PC = 255: INC at 255 wraps to 0.
        rom_b[255] = 8'h81; rom_b[0] = 8'hF0;
        do_reset();
        @(negedge clk); check("t6_c0", {b_addr, b_read}, {8'd255, 1'b1});
        @(negedge clk); check("t6_inc", {b_valid, b_op, b_reg}, {1'b1, 4'h8, 4'h1});
        @(negedge clk); check("t6_wrap", {b_addr, b_read}, {8'd0, 1'b1});

        // RESET_PC = 255: STO operand from 0, next opcode from 1.
        rom_b[255] = 8'h32; rom_b[0] = 8'h77; rom_b[1] = 8'hF0;
        do_reset();
        @(negedge clk); check("t7_c0", b_addr, 8'd255);
        @(negedge clk); check("t7_arg_addr", {b_addr, b_read}, {8'd0, 1'b1});
        @(negedge clk); check("t7_sto", {b_valid, b_op, b_reg, b_arg, b_two}, {1'b1, 4'h3, 4'h2, 8'h77, 1'b1});
        @(negedge clk); check("t7_next_op", {b_addr, b_read}, {8'd1, 1'b1});
        @(negedge clk); check("t7_halted", b_halted, 1);

        // Random ROM images with random back-pressure.
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 256; i++) rom_a[i] = 8'($urandom);
            rand_ready = 1;
            do_reset();
            wait_done();
            rand_ready = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
